// File: rtl/setare_multi_pkg.sv
// ============================================================================
// setare_pkg : shared state encoding and field limits for setare_multi
// Rev 1.0
// ============================================================================
`default_nettype none

package setare_pkg;
    localparam int ORE_W      = 5;
    localparam int MIN_W      = 6;
    localparam int ORE_MAX    = 23;
    localparam int MINUTE_MAX = 59;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SET_TIMP   = 2'd1,
        SET_ALARMA = 2'd2,
        COMMIT     = 2'd3
    } stare_t;
endpackage

`default_nettype wire

// File: rtl/setare_multi_if.sv
// ============================================================================
// setare_multi_if : button/preload inputs and edit/strobe outputs of setare_multi
// Rev 1.0
// ============================================================================
`default_nettype none

interface setare_multi_if
    import setare_pkg::*;
#(
    parameter int NR_ALARME = 4
);
    localparam int CW = (NR_ALARME > 1) ? $clog2(NR_ALARME) : 1;

    logic             semnal_setare;
    logic             semnal_setare_a;
    logic             semnal_sel;
    logic             semnal_b1;
    logic             semnal_b2;
    logic             semnal_stop;
    logic [ORE_W-1:0] ore_crt;
    logic [MIN_W-1:0] minute_crt;
    logic [ORE_W-1:0] ore;
    logic [MIN_W-1:0] minute;
    logic [CW-1:0]    canal;
    logic             load_timp;
    logic             load_alarma;
    logic             activ;

    modport master (
        output semnal_setare, semnal_setare_a, semnal_sel, semnal_b1, semnal_b2,
               semnal_stop, ore_crt, minute_crt,
        input  ore, minute, canal, load_timp, load_alarma, activ
    );

    modport slave (
        input  semnal_setare, semnal_setare_a, semnal_sel, semnal_b1, semnal_b2,
               semnal_stop, ore_crt, minute_crt,
        output ore, minute, canal, load_timp, load_alarma, activ
    );
endinterface

`default_nettype wire

// File: rtl/setare_multi_buton_repeat.sv
// ============================================================================
// buton_repeat : registered press edge plus hold-to-repeat pulse generator
// Rev 1.0
// ============================================================================
`default_nettype none

module buton_repeat #(
    parameter int INTARZIERE_REP = 500,
    parameter int PERIOADA_REP   = 100
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic buton,
    output logic      pas
);
    localparam int MAXC  = (INTARZIERE_REP > PERIOADA_REP) ? INTARZIERE_REP : PERIOADA_REP;
    localparam int CNT_W = $clog2(MAXC + 1);

    logic             r_prev;
    logic             r_rep;
    logic             r_pas;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lim;

    // First wait the initial delay, then switch to the repeat period.
    assign w_lim = r_rep ? CNT_W'(PERIOADA_REP - 1) : CNT_W'(INTARZIERE_REP - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            r_rep  <= 1'b0;
            r_pas  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_prev <= buton;
            r_pas  <= 1'b0;
            if (buton && !r_prev) begin
                r_pas <= 1'b1;
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (buton) begin
                if (r_cnt == w_lim) begin
                    r_pas <= 1'b1;
                    r_cnt <= '0;
                    r_rep <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end
        end
    end

    assign pas = r_pas;
endmodule

`default_nettype wire

// File: rtl/setare_multi.sv
// ============================================================================
// setare_multi : time/alarm hour-minute editor with commit strobes
// Optional inactivity abort: SETARE_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module setare_multi
    import setare_pkg::*;
#(
    parameter int NR_ALARME      = 4,
    parameter int INTARZIERE_REP = 500,
    parameter int PERIOADA_REP   = 100,
    parameter int TIMEOUT        = 10000
) (
    input  wire logic      clock,
    input  wire logic      reset,
    setare_multi_if.slave  bus
);
    localparam int CW = (NR_ALARME > 1) ? $clog2(NR_ALARME) : 1;

    stare_t           r_stare;
    stare_t           w_next;
    logic             r_din_timp;
    logic [ORE_W-1:0] r_ore;
    logic [MIN_W-1:0] r_minute;
    logic [CW-1:0]    r_canal;
    logic             r_sel_prev, r_sel_edge, r_stop_prev, r_stop_edge;
    logic             w_pas1, w_pas2;
    logic             w_edit, w_timeout;
    logic             w_load_timp, w_load_alarma, w_activ;
    logic [ORE_W:0]   w_ore_inc;
    logic [MIN_W:0]   w_min_inc;

    buton_repeat #(.INTARZIERE_REP(INTARZIERE_REP), .PERIOADA_REP(PERIOADA_REP)) u_rep_b1 (
        .clock (clock), .reset (reset), .buton (bus.semnal_b1), .pas (w_pas1));

    buton_repeat #(.INTARZIERE_REP(INTARZIERE_REP), .PERIOADA_REP(PERIOADA_REP)) u_rep_b2 (
        .clock (clock), .reset (reset), .buton (bus.semnal_b2), .pas (w_pas2));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sel_prev  <= 1'b0;
            r_sel_edge  <= 1'b0;
            r_stop_prev <= 1'b0;
            r_stop_edge <= 1'b0;
        end else begin
            r_sel_prev  <= bus.semnal_sel;
            r_sel_edge  <= bus.semnal_sel & ~r_sel_prev;
            r_stop_prev <= bus.semnal_stop;
            r_stop_edge <= bus.semnal_stop & ~r_stop_prev;
        end
    end

`ifdef SETARE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] r_inact;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_inact <= '0;
        end else if (!((r_stare == SET_TIMP) || (r_stare == SET_ALARMA)) ||
                     r_sel_edge || r_stop_edge || w_pas1 || w_pas2) begin
            r_inact <= '0;
        end else if (r_inact != TW'(TIMEOUT - 1)) begin
            r_inact <= r_inact + 1'b1;
        end
    end

    assign w_timeout = (r_inact == TW'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_stare    <= IDLE;
            r_din_timp <= 1'b0;
        end else begin
            r_stare <= w_next;
            if (w_next == COMMIT)
                r_din_timp <= (r_stare == SET_TIMP);
        end
    end

    always_comb begin
        w_next        = r_stare;
        w_load_timp   = 1'b0;
        w_load_alarma = 1'b0;
        w_activ       = 1'b1;
        unique case (r_stare)
            IDLE: begin
                w_activ = 1'b0;
                if (bus.semnal_setare)        w_next = SET_TIMP;
                else if (bus.semnal_setare_a) w_next = SET_ALARMA;
            end
            SET_TIMP: begin
                if (!bus.semnal_setare) w_next = IDLE;
                else if (r_stop_edge)   w_next = COMMIT;
                else if (w_timeout)     w_next = IDLE;
            end
            SET_ALARMA: begin
                if (!bus.semnal_setare_a) w_next = IDLE;
                else if (r_stop_edge)     w_next = COMMIT;
                else if (w_timeout)       w_next = IDLE;
            end
            COMMIT: begin
                w_load_timp   = r_din_timp;
                w_load_alarma = ~r_din_timp;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Edits apply only while the state is held, so stop/abort cycles drop them.
    assign w_edit    = ((r_stare == SET_TIMP) || (r_stare == SET_ALARMA)) && (w_next == r_stare);
    assign w_ore_inc = {1'b0, r_ore} + 1'b1;
    assign w_min_inc = {1'b0, r_minute} + 1'b1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ore    <= '0;
            r_minute <= '0;
            r_canal  <= '0;
        end else if ((r_stare == IDLE) && (w_next == SET_TIMP)) begin
            r_ore    <= (bus.ore_crt > ORE_W'(ORE_MAX))       ? '0 : bus.ore_crt;
            r_minute <= (bus.minute_crt > MIN_W'(MINUTE_MAX)) ? '0 : bus.minute_crt;
        end else if (w_edit) begin
            if (w_pas1)
                r_ore <= (w_ore_inc > (ORE_W+1)'(ORE_MAX)) ? '0 : w_ore_inc[ORE_W-1:0];
            if (w_pas2)
                r_minute <= (w_min_inc > (MIN_W+1)'(MINUTE_MAX)) ? '0 : w_min_inc[MIN_W-1:0];
            if ((r_stare == SET_ALARMA) && r_sel_edge)
                r_canal <= (r_canal == CW'(NR_ALARME - 1)) ? '0 : r_canal + 1'b1;
        end
    end

    assign bus.ore         = r_ore;
    assign bus.minute      = r_minute;
    assign bus.canal       = r_canal;
    assign bus.load_timp   = w_load_timp;
    assign bus.load_alarma = w_load_alarma;
    assign bus.activ       = w_activ;
endmodule

`default_nettype wire

// File: tb/tb_setare_multi.sv
// ============================================================================
// tb_setare_multi : directed self-checking bench for setare_multi
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_setare_multi;
    localparam int NA = 4;
    localparam int D  = 500;
    localparam int P  = 100;
    localparam int TO = 50;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    setare_multi_if #(.NR_ALARME(NA)) bus ();

    setare_multi #(
        .NR_ALARME(NA), .INTARZIERE_REP(D), .PERIOADA_REP(P), .TIMEOUT(TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // which: 1=b1, 2=b2, 3=sel
    task automatic pulse(input int which);
        case (which)
            1: bus.semnal_b1  = 1'b1;
            2: bus.semnal_b2  = 1'b1;
            default: bus.semnal_sel = 1'b1;
        endcase
        tick(1);
        bus.semnal_b1  = 1'b0;
        bus.semnal_b2  = 1'b0;
        bus.semnal_sel = 1'b0;
        tick(1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.semnal_setare   = 1'b0;
        bus.semnal_setare_a = 1'b0;
        bus.semnal_sel      = 1'b0;
        bus.semnal_b1       = 1'b0;
        bus.semnal_b2       = 1'b0;
        bus.semnal_stop     = 1'b0;
        bus.ore_crt         = 5'd7;
        bus.minute_crt      = 6'd33;
        tick(2);
        chk("reset_activ", bus.activ, 0);
        chk("reset_ore", bus.ore, 0);
        reset = 1'b1;
        tick(1);

        // Reset asserted in the middle of a time edit
        bus.semnal_setare = 1'b1;
        tick(1);
        chk("preload_ore", bus.ore, 7);
        chk("preload_activ", bus.activ, 1);
        reset = 1'b0;
        #1;
        chk("rst_mid_ore", bus.ore, 0);
        chk("rst_mid_minute", bus.minute, 0);
        chk("rst_mid_canal", bus.canal, 0);
        chk("rst_mid_activ", bus.activ, 0);
        chk("rst_mid_load", {bus.load_timp, bus.load_alarma}, 0);
        bus.semnal_setare = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(1);

        // Time edit with wrap, no carry between fields
        bus.ore_crt       = 5'd22;
        bus.minute_crt    = 6'd58;
        bus.semnal_setare = 1'b1;
        tick(1);
        chk("time_pre_ore", bus.ore, 22);
        chk("time_pre_min", bus.minute, 58);
        pulse(1);
        chk("b1_once", bus.ore, 23);
        pulse(1);
        chk("b1_wrap", bus.ore, 0);
        pulse(2);
        pulse(2);
        chk("b2_wrap", bus.minute, 0);
        chk("no_carry", bus.ore, 0);
        bus.semnal_stop = 1'b1;
        tick(1);
        chk("stop_lat1", bus.load_timp, 0);
        tick(1);
        chk("stop_lat2_timp", bus.load_timp, 1);
        chk("stop_lat2_alarma", bus.load_alarma, 0);
        chk("commit_activ", bus.activ, 1);
        bus.semnal_stop   = 1'b0;
        bus.semnal_setare = 1'b0;
        tick(1);
        chk("strobe_one_cycle", bus.load_timp, 0);
        chk("post_commit_activ", bus.activ, 0);

        // Alarm edit: channel wrap through sel, minutes kept from before
        bus.semnal_setare_a = 1'b1;
        tick(1);
        chk("alarm_activ", bus.activ, 1);
        chk("alarm_keep_min", bus.minute, 0);
        for (int i = 0; i < 5; i++) pulse(3);
        chk("sel5_canal", bus.canal, 1);
        for (int i = 0; i < 3; i++) pulse(2);
        chk("alarm_min3", bus.minute, 3);
        bus.semnal_stop = 1'b1;
        tick(2);
        chk("alarm_load", bus.load_alarma, 1);
        chk("alarm_no_timp", bus.load_timp, 0);
        chk("alarm_canal", bus.canal, 1);
        bus.semnal_stop     = 1'b0;
        bus.semnal_setare_a = 1'b0;
        tick(1);
        chk("alarm_strobe_end", bus.load_alarma, 0);

        // Auto-repeat: hold b2 for D+3P cycles -> 1 press + 3 repeats
        bus.semnal_setare_a = 1'b1;
        tick(1);
        bus.semnal_b2 = 1'b1;
        tick(D + 3 * P);
        bus.semnal_b2 = 1'b0;
        tick(2);
        chk("hold_min", bus.minute, 7);
        chk("hold_canal", bus.canal, 1);
        bus.semnal_setare_a = 1'b0;
        tick(1);
        chk("abort_activ", bus.activ, 0);
        chk("abort_noload", {bus.load_timp, bus.load_alarma}, 0);
        chk("abort_hold_min", bus.minute, 7);

        // Both requests together -> time edit wins; drop setare -> IDLE
        bus.ore_crt         = 5'd5;
        bus.minute_crt      = 6'd6;
        bus.semnal_setare   = 1'b1;
        bus.semnal_setare_a = 1'b1;
        tick(1);
        chk("both_ore", bus.ore, 5);
        chk("both_min", bus.minute, 6);
        bus.semnal_setare = 1'b0;
        tick(1);
        chk("both_drop_activ", bus.activ, 0);
        chk("both_drop_noload", bus.load_timp, 0);
        bus.semnal_setare_a = 1'b0;
        tick(2);

        // Stop held across entry must not commit
        bus.semnal_stop = 1'b1;
        tick(1);
        bus.semnal_setare = 1'b1;
        tick(1);
        tick(2);
        chk("held_stop_activ", bus.activ, 1);
        chk("held_stop_noload", bus.load_timp, 0);

`ifdef SETARE_TIMEOUT_EN
        tick(TO - 2);
        chk("timeout_activ", bus.activ, 0);
        chk("timeout_noload", bus.load_timp, 0);
`else
        tick(1000);
        chk("no_timeout_activ", bus.activ, 1);
        chk("no_timeout_noload", bus.load_timp, 0);
`endif
        bus.semnal_setare = 1'b0;
        bus.semnal_stop   = 1'b0;
        tick(2);
        chk("final_idle", bus.activ, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
